// File: rtl/mul_share_arb_pkg.sv
// mul_share_arb_pkg: shared types and helpers for the shared multiplier arbiter.
//   state_t  : FSM encoding (IDLE/RUN/RESP)
//   NREQ_DEF : default requester count
//   W_DEF    : default operand width
//   rr_pick  : round-robin winner search (returns -1 when nothing is valid)
package mul_share_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 8;

  // First valid index scanning ptr, ptr+1, ... modulo nreq.
  function automatic int rr_pick(input logic [15:0] valid,
                                 input int unsigned ptr,
                                 input int unsigned nreq);
    int          res;
    int unsigned idx;
    res = -1;
    for (int unsigned off = 0; off < nreq; off++) begin
      idx = (ptr + off) % nreq;
      if (res < 0 && valid[idx[3:0]]) res = int'(idx);
    end
    return res;
  endfunction

endpackage

// File: rtl/mul_share_arb_if.sv
// mul_share_arb_if: request/response bundle for mul_share_arb.
//   req_valid/req_ready : per-requester handshake (NREQ bits)
//   req_a/req_b         : packed operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready : response handshake
//   rsp_id/rsp_c        : owning requester and 2W-bit product
// master = requester/consumer side, slave = arbiter side.
interface mul_share_arb_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [2*W-1:0]    rsp_c;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_c
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_c
  );
endinterface

// File: rtl/mul_share_core.sv
// mul_share_core: sequential unsigned shift-add multiplier, W iterations.
//   clk, rst : clock, synchronous active-high reset
//   start    : latch a/b, clear accumulator and counter, begin iterating
//   a, b     : W-bit operands
//   done     : high during the cycle whose edge completes the last iteration
//   c        : accumulator value written on that edge (the final product)
module mul_share_core #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] c
);
  localparam int CW = $clog2(W);

  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [2*W-1:0] r_acc;
  logic [CW-1:0]  r_cnt;
  logic           r_run;

  logic [2*W-1:0] w_aext;
  logic [2*W-1:0] w_add;
  logic [2*W-1:0] w_acc_nx;

  // Right-shifting accumulator: adding a<<(W-1) and shifting W times
  // leaves b[j] weighted by 2^j without losing low bits.
  always_comb begin
    w_aext   = {{W{1'b0}}, r_a};
    w_add    = r_b[r_cnt] ? (w_aext << (W-1)) : '0;
    w_acc_nx = (r_acc >> 1) + w_add;
  end

  assign done = r_run && (r_cnt == CW'(W-1));
  assign c    = w_acc_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (start) begin
      r_a   <= a;
      r_b   <= b;
      r_acc <= '0;
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_acc <= w_acc_nx;
      r_cnt <= r_cnt + 1'b1;
      if (done) r_run <= 1'b0;
    end
  end
endmodule

// File: rtl/mul_share_arb.sv
// mul_share_arb: NREQ requesters share one W-iteration shift-add multiplier.
// Round-robin grant in IDLE, product returned on one tagged response channel
// with backpressure.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mul_share_arb_if.slave (request and response handshakes)
//   busy     : high whenever the FSM is not IDLE
// Build option: MUL_SHARE_ZERO_BYPASS_EN - a zero operand skips RUN and the
// response (0) is presented one edge after acceptance.
module mul_share_arb
  import mul_share_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  mul_share_arb_if.slave   bus,
  output logic             busy
);
  localparam int IDW = $clog2(NREQ);

  state_t          r_state;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_id;
  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [2*W-1:0]  r_rsp_c;

  int              w_pick;
  logic            w_found;
  logic [IDW-1:0]  w_win;
  logic [IDW-1:0]  w_ptr_nx;
  logic            w_accept;
  logic            w_start;
  logic [W-1:0]    w_a;
  logic [W-1:0]    w_b;
  logic            w_done;
  logic [2*W-1:0]  w_c;
`ifdef MUL_SHARE_ZERO_BYPASS_EN
  logic            w_zero;
`endif

  always_comb begin
    w_pick   = rr_pick(16'(bus.req_valid), 32'(r_ptr), NREQ);
    w_found  = (w_pick >= 0);
    w_win    = IDW'(w_pick);
    w_ptr_nx = (w_win == IDW'(NREQ-1)) ? '0 : w_win + 1'b1;
    w_a      = bus.req_a[int'(w_win)*W +: W];
    w_b      = bus.req_b[int'(w_win)*W +: W];
    w_accept = (r_state == IDLE) && w_found;
    bus.req_ready = '0;
    if (w_accept) bus.req_ready[w_win] = 1'b1;
  end

`ifdef MUL_SHARE_ZERO_BYPASS_EN
  assign w_zero  = (w_a == '0) || (w_b == '0);
  assign w_start = w_accept && !w_zero;
`else
  assign w_start = w_accept;
`endif

  mul_share_core #(.W(W)) u_core (
    .clk   (clk),
    .rst   (rst),
    .start (w_start),
    .a     (w_a),
    .b     (w_b),
    .done  (w_done),
    .c     (w_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_c     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_id  <= w_win;
            r_ptr <= w_ptr_nx;
`ifdef MUL_SHARE_ZERO_BYPASS_EN
            if (w_zero) begin
              r_rsp_c     <= '0;
              r_rsp_id    <= w_win;
              r_rsp_valid <= 1'b1;
              r_state     <= RESP;
            end else begin
              r_state <= RUN;
            end
`else
            r_state <= RUN;
`endif
          end
        end
        RUN: begin
          if (w_done) begin
            r_rsp_c     <= w_c;
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_c     = r_rsp_c;
  assign busy          = (r_state != IDLE);
endmodule

// File: tb/tb_mul_share_arb.sv
module tb_mul_share_arb;
  localparam int NREQ = 4;
  localparam int W    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  mul_share_arb_if #(.NREQ(NREQ), .W(W)) bus ();

  mul_share_arb #(.NREQ(NREQ), .W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          id;
    logic [15:0] c;
  } exp_t;
  exp_t q[$];

  // Transaction-level reference: idle / computing (edges left) / holding.
  typedef enum {M_IDLE, M_BUSY, M_RESP} mstate_t;
  mstate_t m_state = M_IDLE;
  int      m_ptr   = 0;
  int      m_wait  = 0;
  int      m_gcnt[NREQ];

  // Requester-side driver state.
  logic [W-1:0] d_a[NREQ];
  logic [W-1:0] d_b[NREQ];
  logic         d_v[NREQ];
  int           d_g[NREQ];
  logic         persist[NREQ];
  logic         d_rr = 1'b1;
  bit           rand_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom % 8)
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic apply_bus();
    logic [NREQ-1:0]   v;
    logic [NREQ*W-1:0] a, b;
    for (int i = 0; i < NREQ; i++) begin
      v[i]         = d_v[i];
      a[i*W +: W]  = d_a[i];
      b[i*W +: W]  = d_b[i];
    end
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.rsp_ready = d_rr;
  endtask

  // One cycle: retire granted requests, optionally randomize, drive.
  task automatic drive();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (d_v[i] && m_gcnt[i] != d_g[i]) begin
        d_v[i] = 1'b0;
        if (persist[i]) begin
          d_v[i] = 1'b1;
          d_a[i] = rand_op();
          d_b[i] = rand_op();
        end
      end
      d_g[i] = m_gcnt[i];
      if (rand_en) begin
        if (!d_v[i] && ($urandom % 4) == 0) begin
          d_v[i] = 1'b1;
          d_a[i] = rand_op();
          d_b[i] = rand_op();
        end else if (d_v[i] && ($urandom % 40) == 0) begin
          d_v[i] = 1'b0;
        end
      end
    end
    if (rand_en) d_rr = (($urandom % 4) != 0);
    apply_bus();
  endtask

  // Reference model: evaluated mid-cycle for the coming edge.
  initial begin
    int win, lat, idx;
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("rsp_valid", 32'(bus.rsp_valid), 32'(m_state == M_RESP));
      check("busy", 32'(busy), 32'(m_state != M_IDLE));
      win = -1;
      if (m_state == M_IDLE)
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (win < 0 && d_v[idx]) win = idx;
        end
      check("req_ready", 32'(bus.req_ready), (win >= 0) ? (32'd1 << win) : 32'd0);
      if (rst) begin
        m_state = M_IDLE;
        m_ptr   = 0;
        q.delete();
      end else begin
        case (m_state)
          M_IDLE: if (win >= 0) begin
            e.id = win;
            e.c  = 16'(int'(d_a[win]) * int'(d_b[win]));
            q.push_back(e);
            m_gcnt[win]++;
            m_ptr = (win + 1) % NREQ;
            lat = W;
`ifdef MUL_SHARE_ZERO_BYPASS_EN
            if (d_a[win] == 0 || d_b[win] == 0) lat = 1;
`endif
            if (lat == 1) m_state = M_RESP;
            else begin
              m_wait  = lat;
              m_state = M_BUSY;
            end
          end
          M_BUSY: begin
            m_wait--;
            if (m_wait == 0) m_state = M_RESP;
          end
          M_RESP: if (d_rr) m_state = M_IDLE;
          default: m_state = M_IDLE;
        endcase
      end
    end
  end

  // Response monitor: compares whatever the DUT presents with the queue head.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!rst && bus.rsp_valid === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got id=%0d c=%0h expected no response at %0t",
                   bus.rsp_id, bus.rsp_c, $time);
        end else begin
          check("rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
          check("rsp_c", 32'(bus.rsp_c), 32'(q[0].c));
          if (bus.rsp_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      d_v[i] = 1'b0; d_a[i] = '0; d_b[i] = '0; d_g[i] = 0;
      persist[i] = 1'b0; m_gcnt[i] = 0;
    end
    apply_bus();
    rst = 1'b1;
    repeat (3) drive();
    rst = 1'b0;
    check("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("reset_rsp_c", 32'(bus.rsp_c), 32'd0);

    // Single request from requester 1: 0xFE * 0xFE.
    d_v[1] = 1'b1; d_a[1] = 8'hFE; d_b[1] = 8'hFE; d_rr = 1'b1;
    apply_bus();
    repeat (14) drive();

    // All four from reset: a=i+3, b=0x11, grant order 0..3.
    rst = 1'b1; drive(); rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      d_v[i] = 1'b1; d_a[i] = W'(i + 3); d_b[i] = 8'h11;
    end
    apply_bus();
    repeat (45) drive();

    // Requesters 0 and 2 continuously valid: must alternate.
    persist[0] = 1'b1; persist[2] = 1'b1;
    d_v[0] = 1'b1; d_a[0] = 8'h21; d_b[0] = 8'h03;
    d_v[2] = 1'b1; d_a[2] = 8'h07; d_b[2] = 8'h09;
    apply_bus();
    repeat (60) drive();
    persist[0] = 1'b0; persist[2] = 1'b0;
    d_v[0] = 1'b0; d_v[2] = 1'b0;
    apply_bus();
    repeat (12) drive();

    // Backpressure in RESP.
    d_rr = 1'b0;
    d_v[3] = 1'b1; d_a[3] = 8'h0F; d_b[3] = 8'h10;
    apply_bus();
    repeat (15) drive();
    d_rr = 1'b1;
    apply_bus();
    repeat (3) drive();

    // Reset four edges into RUN, then contention from 0 and 3.
    d_v[2] = 1'b1; d_a[2] = 8'h05; d_b[2] = 8'h07;
    apply_bus();
    repeat (5) drive();
    rst = 1'b1; drive(); rst = 1'b0;
    d_v[0] = 1'b1; d_a[0] = 8'h12; d_b[0] = 8'h34;
    d_v[3] = 1'b1; d_a[3] = 8'h56; d_b[3] = 8'h78;
    apply_bus();
    repeat (25) drive();

    // Operand extremes.
    d_v[1] = 1'b1; d_a[1] = 8'hFF; d_b[1] = 8'hFF;
    apply_bus();
    repeat (12) drive();
    d_v[2] = 1'b1; d_a[2] = 8'h00; d_b[2] = 8'h5A;
    apply_bus();
    repeat (12) drive();

    // Randomized traffic with random backpressure.
    rand_en = 1'b1;
    repeat (3000) drive();
    rand_en = 1'b0;
    for (int i = 0; i < NREQ; i++) d_v[i] = 1'b0;
    d_rr = 1'b1;
    apply_bus();
    for (int n = 0; n < 40 && !(m_state == M_IDLE && q.size() == 0); n++) drive();
    drive();
    check("drain_done", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
